ysyx_24110006_axi_arbiter: RTL and testbench

Two-master to one-slave AXI4-Lite arbiter sitting directly upstream of the address-decoding crossbar. It merges the instruction-fetch read port (IFU) and the load/store port (LSU, read and write) into the single master port that feeds the crossbar. It grants one whole transaction at a time. It holds the granted address stable on its output until the response completes, because the crossbar routes response channels combinationally from the live address.

---
 rtl/ysyx_24110006_axi_arbiter_pkg.sv | 27 ++
 rtl/ysyx_24110006_axi_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ysyx_24110006_axi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_axi_arbiter_pkg.sv
// ============================================================================
//  Module   : ysyx_24110006_axi_arbiter_pkg
//  Brief    : Shared types and constants for the IFU/LSU AXI4-Lite arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ysyx_24110006_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } arb_state_t;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    // Encoding of the round-robin history bit: which master was served last.
    localparam logic C_LAST_IFU = 1'b0;
    localparam logic C_LAST_LSU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ysyx_24110006_axi_arbiter.sv
// ============================================================================
//  Module   : ysyx_24110006_axi_arbiter
//  Brief    : Two-master (IFU read, LSU read/write) to one-slave AXI4-Lite
//             arbiter, one whole transaction granted at a time. Optional
//             round-robin IFU/LSU arbitration via macro YSYX_ARB_RR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_24110006_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    // IFU read address / data
    input  logic [ADDR_W-1:0] i_ifu_araddr,
    input  logic              i_ifu_arvalid,
    output logic              o_ifu_arready,
    output logic [DATA_W-1:0] o_ifu_rdata,
    output logic [1:0]        o_ifu_rresp,
    output logic              o_ifu_rvalid,
    input  logic              i_ifu_rready,
    // LSU read address / data
    input  logic [ADDR_W-1:0] i_lsu_araddr,
    input  logic              i_lsu_arvalid,
    output logic              o_lsu_arready,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic [1:0]        o_lsu_rresp,
    output logic              o_lsu_rvalid,
    input  logic              i_lsu_rready,
    // LSU write address / data / response
    input  logic [ADDR_W-1:0] i_lsu_awaddr,
    input  logic              i_lsu_awvalid,
    output logic              o_lsu_awready,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [STRB_W-1:0] i_lsu_wstrb,
    input  logic              i_lsu_wvalid,
    output logic              o_lsu_wready,
    output logic [1:0]        o_lsu_bresp,
    output logic              o_lsu_bvalid,
    input  logic              i_lsu_bready,
    // Downstream master port toward the crossbar
    output logic [ADDR_W-1:0] o_axi_araddr,
    output logic              o_axi_arvalid,
    input  logic              i_axi_arready,
    input  logic [DATA_W-1:0] i_axi_rdata,
    input  logic [1:0]        i_axi_rresp,
    input  logic              i_axi_rvalid,
    output logic              o_axi_rready,
    output logic [ADDR_W-1:0] o_axi_awaddr,
    output logic              o_axi_awvalid,
    input  logic              i_axi_awready,
    output logic [DATA_W-1:0] o_axi_wdata,
    output logic [STRB_W-1:0] o_axi_wstrb,
    output logic              o_axi_wvalid,
    input  logic              i_axi_wready,
    input  logic [1:0]        i_axi_bresp,
    input  logic              i_axi_bvalid,
    output logic              o_axi_bready
);

    import ysyx_24110006_axi_arbiter_pkg::*;

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_araddr;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_ar_pend;
    logic              r_aw_pend;
    logic              r_w_pend;

    logic              w_lsu_wr_req;
    logic              w_last_lsu;
    arb_state_t        w_grant;
    logic              w_ifu_sel;
    logic              w_lsu_rd_sel;
    logic              w_lsu_wr_sel;
    logic              w_r_done;
    logic              w_b_done;

    // On an IFU/LSU collision the master not served last wins; a constant
    // "IFU last" history collapses this into fixed LSU-first priority.
    function automatic arb_state_t f_pick(
        input logic ifu_rd,
        input logic lsu_rd,
        input logic lsu_wr,
        input logic last_lsu
    );
        arb_state_t lsu_st;
        lsu_st = lsu_wr ? ST_LSU_WR : ST_LSU_RD;
        if (ifu_rd && (lsu_rd || lsu_wr)) begin
            return (last_lsu == C_LAST_LSU) ? ST_IFU_RD : lsu_st;
        end else if (lsu_rd || lsu_wr) begin
            return lsu_st;
        end else if (ifu_rd) begin
            return ST_IFU_RD;
        end
        return ST_IDLE;
    endfunction

`ifdef YSYX_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= C_LAST_IFU;
        end else if ((r_state == ST_IDLE) && (w_grant != ST_IDLE)) begin
            r_last_grant <= (w_grant == ST_IFU_RD) ? C_LAST_IFU : C_LAST_LSU;
        end
    end

    assign w_last_lsu = r_last_grant;
`else
    assign w_last_lsu = C_LAST_IFU;
`endif

    assign w_lsu_wr_req = i_lsu_awvalid | i_lsu_wvalid;
    assign w_grant      = f_pick(i_ifu_arvalid, i_lsu_arvalid, w_lsu_wr_req, w_last_lsu);

    assign w_ifu_sel    = (r_state == ST_IFU_RD);
    assign w_lsu_rd_sel = (r_state == ST_LSU_RD);
    assign w_lsu_wr_sel = (r_state == ST_LSU_WR);
    assign w_r_done     = i_axi_rvalid & o_axi_rready;
    assign w_b_done     = i_axi_bvalid & o_axi_bready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_ar_pend <= 1'b0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= w_grant;
                    case (w_grant)
                        ST_IFU_RD: begin
                            r_araddr  <= i_ifu_araddr;
                            r_ar_pend <= 1'b1;
                        end
                        ST_LSU_RD: begin
                            r_araddr  <= i_lsu_araddr;
                            r_ar_pend <= 1'b1;
                        end
                        ST_LSU_WR: begin
                            r_awaddr  <= i_lsu_awaddr;
                            r_wdata   <= i_lsu_wdata;
                            r_wstrb   <= i_lsu_wstrb;
                            r_aw_pend <= 1'b1;
                            r_w_pend  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_IFU_RD, ST_LSU_RD: begin
                    if (r_ar_pend && i_axi_arready) begin
                        r_ar_pend <= 1'b0;
                    end
                    // An early response (still ar_pend) also ends the transaction.
                    if (w_r_done) begin
                        r_ar_pend <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_LSU_WR: begin
                    if (r_aw_pend && i_axi_awready) begin
                        r_aw_pend <= 1'b0;
                    end
                    if (r_w_pend && i_axi_wready) begin
                        r_w_pend <= 1'b0;
                    end
                    if (w_b_done) begin
                        r_aw_pend <= 1'b0;
                        r_w_pend  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Downstream request side comes straight from the latch registers so the
    // crossbar sees a stable address for the whole transaction.
    assign o_axi_araddr  = r_araddr;
    assign o_axi_arvalid = r_ar_pend;
    assign o_axi_awaddr  = r_awaddr;
    assign o_axi_awvalid = r_aw_pend;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_wvalid  = r_w_pend;

    assign o_axi_rready  = (w_ifu_sel & i_ifu_rready) | (w_lsu_rd_sel & i_lsu_rready);
    assign o_axi_bready  = w_lsu_wr_sel & i_lsu_bready;

    assign o_ifu_arready = w_ifu_sel & r_ar_pend & i_axi_arready;
    assign o_ifu_rvalid  = w_ifu_sel & i_axi_rvalid;
    assign o_ifu_rdata   = w_ifu_sel ? i_axi_rdata : '0;
    assign o_ifu_rresp   = w_ifu_sel ? i_axi_rresp : C_RESP_OKAY;

    assign o_lsu_arready = w_lsu_rd_sel & r_ar_pend & i_axi_arready;
    assign o_lsu_rvalid  = w_lsu_rd_sel & i_axi_rvalid;
    assign o_lsu_rdata   = w_lsu_rd_sel ? i_axi_rdata : '0;
    assign o_lsu_rresp   = w_lsu_rd_sel ? i_axi_rresp : C_RESP_OKAY;

    assign o_lsu_awready = w_lsu_wr_sel & r_aw_pend & i_axi_awready;
    assign o_lsu_wready  = w_lsu_wr_sel & r_w_pend & i_axi_wready;
    assign o_lsu_bvalid  = w_lsu_wr_sel & i_axi_bvalid;
    assign o_lsu_bresp   = w_lsu_wr_sel ? i_axi_bresp : C_RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// ============================================================================
//  Module   : tb_ysyx_24110006_axi_arbiter
//  Brief    : Directed, table-driven bench for the IFU/LSU AXI4-Lite arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_24110006_axi_arbiter;

    import ysyx_24110006_axi_arbiter_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] i_ifu_araddr;
    logic        i_ifu_arvalid;
    logic        o_ifu_arready;
    logic [31:0] o_ifu_rdata;
    logic [1:0]  o_ifu_rresp;
    logic        o_ifu_rvalid;
    logic        i_ifu_rready;
    logic [31:0] i_lsu_araddr;
    logic        i_lsu_arvalid;
    logic        o_lsu_arready;
    logic [31:0] o_lsu_rdata;
    logic [1:0]  o_lsu_rresp;
    logic        o_lsu_rvalid;
    logic        i_lsu_rready;
    logic [31:0] i_lsu_awaddr;
    logic        i_lsu_awvalid;
    logic        o_lsu_awready;
    logic [31:0] i_lsu_wdata;
    logic [7:0]  i_lsu_wstrb;
    logic        i_lsu_wvalid;
    logic        o_lsu_wready;
    logic [1:0]  o_lsu_bresp;
    logic        o_lsu_bvalid;
    logic        i_lsu_bready;
    logic [31:0] o_axi_araddr;
    logic        o_axi_arvalid;
    logic        i_axi_arready;
    logic [31:0] i_axi_rdata;
    logic [1:0]  i_axi_rresp;
    logic        i_axi_rvalid;
    logic        o_axi_rready;
    logic [31:0] o_axi_awaddr;
    logic        o_axi_awvalid;
    logic        i_axi_awready;
    logic [31:0] o_axi_wdata;
    logic [7:0]  o_axi_wstrb;
    logic        o_axi_wvalid;
    logic        i_axi_wready;
    logic [1:0]  i_axi_bresp;
    logic        i_axi_bvalid;
    logic        o_axi_bready;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_24110006_axi_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STRB_W(8)
    ) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_ifu_araddr (i_ifu_araddr),
        .i_ifu_arvalid(i_ifu_arvalid),
        .o_ifu_arready(o_ifu_arready),
        .o_ifu_rdata  (o_ifu_rdata),
        .o_ifu_rresp  (o_ifu_rresp),
        .o_ifu_rvalid (o_ifu_rvalid),
        .i_ifu_rready (i_ifu_rready),
        .i_lsu_araddr (i_lsu_araddr),
        .i_lsu_arvalid(i_lsu_arvalid),
        .o_lsu_arready(o_lsu_arready),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_rresp  (o_lsu_rresp),
        .o_lsu_rvalid (o_lsu_rvalid),
        .i_lsu_rready (i_lsu_rready),
        .i_lsu_awaddr (i_lsu_awaddr),
        .i_lsu_awvalid(i_lsu_awvalid),
        .o_lsu_awready(o_lsu_awready),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_wstrb  (i_lsu_wstrb),
        .i_lsu_wvalid (i_lsu_wvalid),
        .o_lsu_wready (o_lsu_wready),
        .o_lsu_bresp  (o_lsu_bresp),
        .o_lsu_bvalid (o_lsu_bvalid),
        .i_lsu_bready (i_lsu_bready),
        .o_axi_araddr (o_axi_araddr),
        .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready),
        .i_axi_rdata  (i_axi_rdata),
        .i_axi_rresp  (i_axi_rresp),
        .i_axi_rvalid (i_axi_rvalid),
        .o_axi_rready (o_axi_rready),
        .o_axi_awaddr (o_axi_awaddr),
        .o_axi_awvalid(o_axi_awvalid),
        .i_axi_awready(i_axi_awready),
        .o_axi_wdata  (o_axi_wdata),
        .o_axi_wstrb  (o_axi_wstrb),
        .o_axi_wvalid (o_axi_wvalid),
        .i_axi_wready (i_axi_wready),
        .i_axi_bresp  (i_axi_bresp),
        .i_axi_bvalid (i_axi_bvalid),
        .o_axi_bready (o_axi_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_dly;
        int          r_dly;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } rd_vec_t;

    rd_vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts in the cycle right after the grant edge and ends in the IDLE
    // bubble following the R handshake.
    task automatic finish_read(input bit lsu, input logic [31:0] addr,
                               input logic [31:0] rdata, input logic [1:0] rresp,
                               input int ar_dly, input int r_dly,
                               input logic [31:0] exp_rdata, input logic [1:0] exp_rresp);
        check("ar_grant_valid", o_axi_arvalid, 1);
        check("ar_grant_addr", o_axi_araddr, addr);
        for (int i = 0; i < ar_dly; i++) begin
            check("ar_wait_noready", lsu ? o_lsu_arready : o_ifu_arready, 0);
            tick();
            check("ar_hold_addr", o_axi_araddr, addr);
            check("ar_hold_valid", o_axi_arvalid, 1);
        end
        i_axi_arready = 1'b1;
        #1;
        check("ar_ready_granted", lsu ? o_lsu_arready : o_ifu_arready, 1);
        check("ar_ready_other", lsu ? o_ifu_arready : o_lsu_arready, 0);
        tick();
        i_axi_arready = 1'b0;
        if (lsu) i_lsu_arvalid = 1'b0;
        else     i_ifu_arvalid = 1'b0;
        #1;
        check("ar_valid_drop", o_axi_arvalid, 0);
        for (int j = 0; j < r_dly; j++) begin
            check("r_wait_addr", o_axi_araddr, addr);
            check("r_wait_novalid", lsu ? o_lsu_rvalid : o_ifu_rvalid, 0);
            tick();
        end
        i_axi_rvalid = 1'b1;
        i_axi_rdata  = rdata;
        i_axi_rresp  = rresp;
        i_ifu_rready = 1'b1;
        i_lsu_rready = 1'b1;
        #1;
        check("r_addr_stable", o_axi_araddr, addr);
        check("r_valid_granted", lsu ? o_lsu_rvalid : o_ifu_rvalid, 1);
        check("r_data_granted", lsu ? o_lsu_rdata : o_ifu_rdata, exp_rdata);
        check("r_resp_granted", lsu ? o_lsu_rresp : o_ifu_rresp, exp_rresp);
        check("r_valid_other", lsu ? o_ifu_rvalid : o_lsu_rvalid, 0);
        check("r_data_other", lsu ? o_ifu_rdata : o_lsu_rdata, 0);
        check("r_resp_other", lsu ? o_ifu_rresp : o_lsu_rresp, 0);
        check("r_rready_out", o_axi_rready, 1);
        tick();
        i_axi_rvalid = 1'b0;
        i_axi_rdata  = '0;
        i_axi_rresp  = '0;
        #1;
        check("idle_rready", o_axi_rready, 0);
        check("idle_arvalid", o_axi_arvalid, 0);
        i_ifu_rready = 1'b0;
        i_lsu_rready = 1'b0;
    endtask

    task automatic do_read(input rd_vec_t v);
        if (v.lsu) begin
            i_lsu_araddr  = v.addr;
            i_lsu_arvalid = 1'b1;
        end else begin
            i_ifu_araddr  = v.addr;
            i_ifu_arvalid = 1'b1;
        end
        #1;
        check("grant_latency", o_axi_arvalid, 0);
        tick();
        finish_read(v.lsu, v.addr, v.rdata, v.rresp, v.ar_dly, v.r_dly, v.exp_rdata, v.exp_rresp);
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
        i_lsu_awaddr  = addr;
        i_lsu_wdata   = data;
        i_lsu_wstrb   = strb;
        i_lsu_awvalid = 1'b1;
        i_lsu_wvalid  = 1'b1;
        #1;
        check("wr_grant_latency", o_axi_awvalid, 0);
        tick();
        check("wr_awvalid", o_axi_awvalid, 1);
        check("wr_wvalid", o_axi_wvalid, 1);
        check("wr_awaddr", o_axi_awaddr, addr);
        check("wr_wdata", o_axi_wdata, data);
        check("wr_wstrb", o_axi_wstrb, strb);
    endtask

    initial begin
        vecs[0] = '{lsu:1'b0, addr:32'h8000_0000, rdata:32'h1234_5678, rresp:C_RESP_OKAY,
                    ar_dly:0, r_dly:0, exp_rdata:32'h1234_5678, exp_rresp:2'b00};
        vecs[1] = '{lsu:1'b0, addr:32'h8000_0010, rdata:32'hdead_beef, rresp:C_RESP_OKAY,
                    ar_dly:5, r_dly:3, exp_rdata:32'hdead_beef, exp_rresp:2'b00};
        vecs[2] = '{lsu:1'b1, addr:32'ha000_0000, rdata:32'h0000_0bad, rresp:C_RESP_SLVERR,
                    ar_dly:1, r_dly:1, exp_rdata:32'h0000_0bad, exp_rresp:2'b10};
        vecs[3] = '{lsu:1'b1, addr:32'h8000_1000, rdata:32'hcafe_f00d, rresp:C_RESP_OKAY,
                    ar_dly:2, r_dly:0, exp_rdata:32'hcafe_f00d, exp_rresp:2'b00};

        reset_n = 1'b0;
        i_ifu_araddr = '0; i_ifu_arvalid = 1'b0; i_ifu_rready = 1'b0;
        i_lsu_araddr = '0; i_lsu_arvalid = 1'b0; i_lsu_rready = 1'b0;
        i_lsu_awaddr = '0; i_lsu_awvalid = 1'b0;
        i_lsu_wdata  = '0; i_lsu_wstrb   = '0;   i_lsu_wvalid = 1'b0;
        i_lsu_bready = 1'b0;
        i_axi_arready = 1'b0; i_axi_rdata = '0; i_axi_rresp = '0; i_axi_rvalid = 1'b0;
        i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_bresp = '0; i_axi_bvalid = 1'b0;
        tick();
        tick();

        check("rst_arvalid", o_axi_arvalid, 0);
        check("rst_awvalid", o_axi_awvalid, 0);
        check("rst_wvalid", o_axi_wvalid, 0);
        check("rst_araddr", o_axi_araddr, 0);
        check("rst_awaddr", o_axi_awaddr, 0);
        check("rst_wdata", o_axi_wdata, 0);
        check("rst_wstrb", o_axi_wstrb, 0);
        check("rst_rready", o_axi_rready, 0);
        check("rst_bready", o_axi_bready, 0);
        check("rst_ifu_rvalid", o_ifu_rvalid, 0);
        check("rst_lsu_bvalid", o_lsu_bvalid, 0);
        reset_n = 1'b1;
        tick();

        // Collision right after reset: LSU wins in both arbitration modes.
        i_ifu_araddr  = 32'h8000_0100;
        i_ifu_arvalid = 1'b1;
        i_lsu_araddr  = 32'h8000_0200;
        i_lsu_arvalid = 1'b1;
        #1;
        check("coll_no_comb_path", o_axi_arvalid, 0);
        tick();
        finish_read(1'b1, 32'h8000_0200, 32'h0000_1111, C_RESP_OKAY, 0, 0, 32'h0000_1111, 2'b00);
        i_lsu_araddr  = 32'h8000_0300;
        i_lsu_arvalid = 1'b1;
        tick();
`ifdef YSYX_ARB_RR_EN
        finish_read(1'b0, 32'h8000_0100, 32'h0000_2222, C_RESP_OKAY, 1, 0, 32'h0000_2222, 2'b00);
        tick();
        finish_read(1'b1, 32'h8000_0300, 32'h0000_3333, C_RESP_OKAY, 0, 1, 32'h0000_3333, 2'b00);
`else
        finish_read(1'b1, 32'h8000_0300, 32'h0000_3333, C_RESP_OKAY, 1, 0, 32'h0000_3333, 2'b00);
        tick();
        finish_read(1'b0, 32'h8000_0100, 32'h0000_2222, C_RESP_OKAY, 0, 1, 32'h0000_2222, 2'b00);
`endif

        for (int k = 0; k < 4; k++) begin
            do_read(vecs[k]);
        end

        // Write with W accepted two cycles ahead of AW.
        start_write(32'ha000_03f8, 32'h0000_0041, 8'h01);
        i_axi_wready = 1'b1;
        #1;
        check("wr_wready_pulse", o_lsu_wready, 1);
        check("wr_awready_early", o_lsu_awready, 0);
        tick();
        i_axi_wready = 1'b0;
        i_lsu_wvalid = 1'b0;
        #1;
        check("wr_wvalid_drop", o_axi_wvalid, 0);
        check("wr_awvalid_hold", o_axi_awvalid, 1);
        check("wr_awaddr_hold1", o_axi_awaddr, 32'ha000_03f8);
        tick();
        check("wr_awaddr_hold2", o_axi_awaddr, 32'ha000_03f8);
        check("wr_bvalid_early", o_lsu_bvalid, 0);
        i_axi_awready = 1'b1;
        #1;
        check("wr_awready_pulse", o_lsu_awready, 1);
        tick();
        i_axi_awready = 1'b0;
        i_lsu_awvalid = 1'b0;
        #1;
        check("wr_awvalid_drop", o_axi_awvalid, 0);
        check("wr_awaddr_hold3", o_axi_awaddr, 32'ha000_03f8);
        i_axi_bvalid = 1'b1;
        i_axi_bresp  = C_RESP_OKAY;
        i_lsu_bready = 1'b1;
        #1;
        check("wr_bvalid", o_lsu_bvalid, 1);
        check("wr_bresp", o_lsu_bresp, 2'b00);
        check("wr_bready_out", o_axi_bready, 1);
        check("wr_ifu_rvalid", o_ifu_rvalid, 0);
        tick();
        i_axi_bvalid = 1'b0;
        #1;
        check("wr_single_bvalid", o_lsu_bvalid, 0);
        check("wr_idle_bready", o_axi_bready, 0);
        i_lsu_bready = 1'b0;

        // Reset in the middle of a write, after AW has completed.
        start_write(32'ha000_0040, 32'h5a5a_a5a5, 8'h0f);
        i_axi_awready = 1'b1;
        tick();
        i_axi_awready = 1'b0;
        i_lsu_awvalid = 1'b0;
        #1;
        check("mid_aw_done", o_axi_awvalid, 0);
        check("mid_w_pending", o_axi_wvalid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wvalid", o_axi_wvalid, 0);
        check("mid_rst_awvalid", o_axi_awvalid, 0);
        check("mid_rst_awaddr", o_axi_awaddr, 0);
        check("mid_rst_wdata", o_axi_wdata, 0);
        check("mid_rst_wstrb", o_axi_wstrb, 0);
        check("mid_rst_lsu_wready", o_lsu_wready, 0);
        i_lsu_wvalid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_read('{lsu:1'b0, addr:32'h8000_0004, rdata:32'h0bad_cafe, rresp:C_RESP_OKAY,
                  ar_dly:1, r_dly:1, exp_rdata:32'h0bad_cafe, exp_rresp:2'b00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
